// File: rtl/ps2_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ps2_tx
// Purpose  : PS/2 host-to-device transmitter. Sends one command byte to the
//            device over the shared PS2_CLK/PS2_DAT pair using open-drain
//            output enables, and reports completion, ACK/NACK and timeout.
// Ports    : clock, reset_n         - system clock, async active-low reset
//            start, data[7:0]       - one-cycle request and byte to send
//            ps_clock_i, ps_data_i  - pad inputs (asynchronous)
//            ps_clock_oe, ps_data_oe- 1 = pull the line low, 0 = release
//            busy, done, status[1:0]- progress, end pulse, 00 ok/01 nack/10 tmo
// Revision : 1.0 - initial release
// ============================================================================
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000,
  parameter int FILTER         = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       ps_clock_i,
  input  logic       ps_data_i,
  output logic       ps_clock_oe,
  output logic       ps_data_oe,
  output logic       busy,
  output logic       done,
  output logic [1:0] status
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int FW = (FILTER > 1) ? $clog2(FILTER) : 1;

  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_RELEASE   = 3'd2;
  localparam logic [2:0] S_SEND      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  // Line conditioning: bit 0 = clock, bit 1 = data.
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    filt_q, filt_d;
  logic [FW-1:0] fcnt_q [2];
  logic [FW-1:0] fcnt_d [2];
  logic          fe_q, fe_d;

  logic [2:0]    state_q, state_d;
  logic [7:0]    data_q, data_d;
  logic [IW-1:0] inh_q, inh_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [3:0]    n_q, n_d;
  logic          clock_oe_q, clock_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [1:0]    status_q, status_d;
  logic          w_parity;
  logic          w_wd_run;

  // A line level is accepted only after FILTER consecutive samples disagree
  // with the current filtered level; any agreeing sample restarts the count.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      fcnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FLT_LAST) filt_d[i] = sync2_q[i];
        else                       fcnt_d[i] = fcnt_q[i] + 1'b1;
      end
    end
    fe_d = filt_q[0] & ~filt_d[0];
  end

  assign w_parity = ~^data_q;
  assign w_wd_run = (state_q == S_SEND) || (state_q == S_WAIT_IDLE);

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    inh_d      = inh_q;
    n_d        = n_q;
    clock_oe_d = clock_oe_q;
    data_oe_d  = data_oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    status_d   = status_q;
    wd_d       = '0;
    if (w_wd_run && !fe_q) wd_d = wd_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        clock_oe_d = 1'b0;
        data_oe_d  = 1'b0;
        // busy stays high for the done cycle, so a start coinciding with
        // done is dropped and the next one is taken a cycle later.
        if (start && !busy_q) begin
          data_d     = data;
          busy_d     = 1'b1;
          status_d   = 2'b00;
          inh_d      = '0;
          clock_oe_d = 1'b1;
          state_d    = S_INHIBIT;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_INHIBIT: begin
        if (inh_q == INH_LAST) begin
          data_oe_d  = 1'b1;          // start bit
          clock_oe_d = 1'b0;
          state_d    = S_RELEASE;
        end else begin
          inh_d = inh_q + 1'b1;
        end
      end
      S_RELEASE: begin
        n_d     = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        // Updates are registered off fe, so the line moves while the device
        // still holds the clock low and is stable for its rising edge.
        if (fe_q) begin
          n_d = n_q + 4'd1;
          case (n_q)
            4'd0, 4'd1, 4'd2, 4'd3,
            4'd4, 4'd5, 4'd6, 4'd7: data_oe_d = ~data_q[n_q[2:0]];
            4'd8:  data_oe_d = ~w_parity;
            4'd9:  data_oe_d = 1'b0;  // stop bit: line released
            4'd10: begin
              status_d = {1'b0, filt_q[1]};
              state_d  = S_WAIT_IDLE;
            end
            default: ;
          endcase
        end
      end
      S_WAIT_IDLE: begin
        if (filt_q == 2'b11) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        clock_oe_d = 1'b0;
        data_oe_d  = 1'b0;
        state_d    = S_IDLE;
      end
    endcase

    if (w_wd_run && !fe_q && (wd_q == WD_LAST)) begin
      clock_oe_d = 1'b0;
      data_oe_d  = 1'b0;
      status_d   = 2'b10;
      done_d     = 1'b1;
      state_d    = S_IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      filt_q     <= 2'b11;
      fcnt_q[0]  <= '0;
      fcnt_q[1]  <= '0;
      fe_q       <= 1'b0;
      state_q    <= S_IDLE;
      data_q     <= '0;
      inh_q      <= '0;
      wd_q       <= '0;
      n_q        <= '0;
      clock_oe_q <= 1'b0;
      data_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      status_q   <= 2'b00;
    end else begin
      sync1_q    <= {ps_data_i, ps_clock_i};
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      fcnt_q[0]  <= fcnt_d[0];
      fcnt_q[1]  <= fcnt_d[1];
      fe_q       <= fe_d;
      state_q    <= state_d;
      data_q     <= data_d;
      inh_q      <= inh_d;
      wd_q       <= wd_d;
      n_q        <= n_d;
      clock_oe_q <= clock_oe_d;
      data_oe_q  <= data_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      status_q   <= status_d;
    end
  end

  assign ps_clock_oe = clock_oe_q;
  assign ps_data_oe  = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign status      = status_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ps2_tx
// Purpose  : Self-checking bench for ps2_tx with a behavioural PS/2 device
//            (40-cycle bit period) and a frame/status reference model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_tx;

  localparam int INH  = 20;
  localparam int TMO  = 400;
  localparam int FLT  = 2;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] data;
  logic       dev_clk;     // 1 = device pulls PS2_CLK low
  logic       dev_dat;     // 1 = device pulls PS2_DAT low
  logic       ps_clock_i, ps_data_i;
  logic       ps_clock_oe, ps_data_oe, busy, done;
  logic [1:0] status;

  int n_vec    = 0;
  int n_err    = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  assign ps_clock_i = ~(ps_clock_oe | dev_clk);
  assign ps_data_i  = ~(ps_data_oe  | dev_dat);

  ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER(FLT)) dut (
    .clock       (clk),
    .reset_n     (reset_n),
    .start       (start),
    .data        (data),
    .ps_clock_i  (ps_clock_i),
    .ps_data_i   (ps_data_i),
    .ps_clock_oe (ps_clock_oe),
    .ps_data_oe  (ps_data_oe),
    .busy        (busy),
    .done        (done),
    .status      (status)
  );

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: what the device should see on its ten rising edges.
  function automatic logic [9:0] ref_frame(input logic [7:0] d);
    logic p;
    p = ($countones(d) % 2 == 0);
    return {1'b1, p, d};
  endfunction

  function automatic logic [1:0] ref_status(input bit ack);
    return ack ? 2'b00 : 2'b01;
  endfunction

  task automatic send(input logic [7:0] d);
    start = 1'b1;
    data  = d;
    tick();
    start = 1'b0;
    chk("busy_rise", busy, 1);
  endtask

  task automatic dev_xfer(input bit ack, input int glitch_at, input int start_at,
                          input int reset_at, output logic [9:0] frame,
                          output int inh_len, output bit aborted);
    bit found;
    frame   = '0;
    inh_len = 0;
    aborted = 1'b0;
    found   = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (ps_clock_oe) inh_len++;
      else if (ps_clock_i && !ps_data_i) found = 1'b1;
      if (!found) tick();
    end
    chk("start_cond", found, 1);
    if (!found) begin
      aborted = 1'b1;
      return;
    end
    repeat (10) tick();
    for (int i = 1; i <= 11; i++) begin
      if (i == 11 && ack) dev_dat = 1'b1;
      dev_clk = 1'b1;
      for (int k = 0; k < HALF; k++) begin
        tick();
        if (i == start_at && k == 5) begin
          start = 1'b1;
          data  = ~data;
        end
        if (i == start_at && k == 6) begin
          start = 1'b0;
          chk("busy_hold", busy, 1);
        end
        if (i == reset_at && k == 10) begin
          chk("pre_rst_doe", ps_data_oe, 1);
          reset_n = 1'b0;
          #1;
          chk("rst_oe", {ps_clock_oe, ps_data_oe}, 0);
          chk("rst_busy", busy, 0);
          dev_clk = 1'b0;
          dev_dat = 1'b0;
          aborted = 1'b1;
          repeat (3) tick();
          reset_n = 1'b1;
          return;
        end
      end
      dev_clk = 1'b0;
      if (i <= 10) begin
        frame[i-1] = ps_data_i;
        for (int k = 0; k < HALF; k++) begin
          tick();
          if (i == glitch_at && k == 8) dev_clk = 1'b1;
          if (i == glitch_at && k == 9) dev_clk = 1'b0;
        end
      end else begin
        dev_dat = 1'b0;
      end
    end
  endtask

  task automatic wait_done(input bit poke_start, output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    while (cycles < 700 && !seen) begin
      tick();
      cycles++;
      if (done) seen = 1'b1;
    end
    if (seen && poke_start) begin
      start = 1'b1;
      data  = 8'h55;
      tick();
      start = 1'b0;
      chk("start_at_done_ignored", busy, 0);
      tick();
      chk("start_at_done_late", busy, 0);
    end else begin
      repeat (2) tick();
    end
  endtask

  task automatic xfer(input logic [7:0] d, input bit ack, input int glitch_at,
                      input int start_at, input int reset_at, input bit poke);
    logic [9:0] frame;
    int         inh_len, cyc, base;
    bit         aborted, seen;
    base = done_cnt;
    send(d);
    dev_xfer(ack, glitch_at, start_at, reset_at, frame, inh_len, aborted);
    chk("inhibit_len", inh_len, INH);
    if (aborted) begin
      repeat (30) tick();
      chk("rst_no_done", done_cnt, base);
      chk("rst_busy_after", busy, 0);
      chk("rst_status", status, 0);
      return;
    end
    chk("frame", frame, ref_frame(d));
    wait_done(poke, cyc, seen);
    chk("done_seen", seen, 1);
    chk("status", status, ref_status(ack));
    chk("done_pulses", done_cnt - base, 1);
    chk("oe_idle", {ps_clock_oe, ps_data_oe}, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int         cyc, base;
    bit         seen;
    logic [7:0] d;
    reset_n = 1'b0;
    start   = 1'b0;
    data    = 8'h00;
    dev_clk = 1'b0;
    dev_dat = 1'b0;
    repeat (3) tick();
    chk("reset_outs", {ps_clock_oe, ps_data_oe, busy, done, status}, 0);
    reset_n = 1'b1;
    repeat (3) tick();

    xfer(8'hED, 1'b1, 0, 0, 0, 1'b1);   // ACK, plus start coinciding with done
    xfer(8'hF4, 1'b0, 0, 0, 0, 1'b0);   // NACK

    // Device never clocks.
    base = done_cnt;
    send(8'h3C);
    wait_done(1'b0, cyc, seen);
    chk("tmo_seen", seen, 1);
    chk("tmo_window", (cyc >= INH + TMO - 10 && cyc <= INH + TMO + 15), 1);
    chk("tmo_status", status, 2'b10);
    chk("tmo_oe", {ps_clock_oe, ps_data_oe}, 0);
    chk("tmo_pulses", done_cnt - base, 1);

    xfer(8'h96, 1'b1, 0, 5, 0, 1'b0);   // second start mid-transfer
    xfer(8'hA0, 1'b1, 0, 0, 3, 1'b0);   // reset during bit 3
    xfer(8'hED, 1'b1, 0, 0, 0, 1'b0);   // clean send after reset
    xfer(8'hED, 1'b1, 4, 0, 0, 1'b0);   // clock glitch while high

    for (int t = 0; t < 8; t++) begin
      d = 8'($urandom);
      xfer(d, 1'($urandom_range(0, 1)), int'($urandom_range(0, 10)), 0, 0,
           1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
